// File: rtl/a_bus_pkg.sv
// Shared types and constants for the A_Bus device-side responder.
// Holds the FSM state enum, default bus widths and the address-to-index helper.
package a_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned WR_BIT     = ADDR_W_DEF - 1;
  localparam logic [63:0] ERR_DATA   = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT
  } resp_state_e;

  // Register index is every address bit below the write flag.
  function automatic int unsigned idx_of(input logic [31:0] a, input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << (aw - 1)) - 32'd1;
    return a & mask;
  endfunction

endpackage

// File: rtl/a_bus_regfile.sv
// NUM_REGS x DATA_W register file: one synchronous write port cleared by rst,
// plus combinational bus and debug read ports that return 0 out of range.
module a_bus_regfile
  import a_bus_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [6:0]        w_idx,
  input  logic [DATA_W-1:0] w_data,
  input  logic [6:0]        rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic [6:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_idx == 7'(i)) mem_d[i] = w_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  // Decoded reads avoid array-index width issues when NUM_REGS is not a power of two.
  always_comb begin
    rd_data  = '0;
    dbg_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == 7'(i))  rd_data  = mem_q[i];
      if (dbg_idx == 7'(i)) dbg_data = mem_q[i];
    end
  end

endmodule

// File: rtl/a_bus_responder.sv
// Device-side end of the A_Bus req/gnt protocol: grants each request after
// GNT_DELAY cycles and serves reads/writes against an internal register file.
module a_bus_responder
  import a_bus_pkg::*;
#(
  parameter int unsigned GNT_DELAY = 2,
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              gnt,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe,
  output logic              err,
  output logic [15:0]       txn_cnt,
  input  logic [6:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  if (GNT_DELAY < 1 || GNT_DELAY > 3) begin : g_bad_delay
    $error("a_bus_responder: GNT_DELAY must be 1..3");
  end
  if (NUM_REGS < 1 || NUM_REGS > 128) begin : g_bad_regs
    $error("a_bus_responder: NUM_REGS must be 1..128");
  end
  if (ADDR_W < 2 || ADDR_W > 32 || DATA_W < 1 || DATA_W > 64) begin : g_bad_width
    $error("a_bus_responder: unsupported ADDR_W/DATA_W");
  end

  // Offset from the package default keeps the write flag at the MSB for any ADDR_W.
  localparam int unsigned WR = WR_BIT + ADDR_W - ADDR_W_DEF;

  resp_state_e       state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic              gnt_q, gnt_d;
  logic [DATA_W-1:0] data_o_q, data_o_d;
  logic              data_oe_q, data_oe_d;
  logic              err_q, err_d;
  logic [15:0]       txn_cnt_q, txn_cnt_d;

  int unsigned       idx_d, idx_q;
  logic              in_rng_d, in_rng_q;
  logic              grant_d, rd_d, we;
  logic [DATA_W-1:0] rf_rd;

  assign idx_d    = idx_of(32'(a_d), ADDR_W);
  assign idx_q    = idx_of(32'(a_q), ADDR_W);
  assign in_rng_d = idx_d < NUM_REGS;
  assign in_rng_q = idx_q < NUM_REGS;

  a_bus_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .w_idx    (7'(idx_q)),
    .w_data   (data_i),
    .rd_idx   (7'(idx_d)),
    .rd_data  (rf_rd),
    .dbg_idx  (dbg_idx),
    .dbg_data (dbg_data)
  );

  // Outputs are computed from the next state so they line up with the GRANT cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          a_d     = addr;
          cnt_d   = 2'(GNT_DELAY - 1);
          state_d = (GNT_DELAY == 1) ? GRANT : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = GRANT;
      end
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    grant_d   = (state_d == GRANT);
    rd_d      = grant_d && !a_d[WR];
    gnt_d     = grant_d;
    data_oe_d = rd_d;
    err_d     = grant_d && !in_rng_d;
    data_o_d  = '0;
    if (rd_d) data_o_d = in_rng_d ? rf_rd : DATA_W'(ERR_DATA);

    we        = (state_q == GRANT) && a_q[WR] && in_rng_q;
    txn_cnt_d = txn_cnt_q;
    if (state_q == GRANT && txn_cnt_q != '1) txn_cnt_d = txn_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      gnt_q     <= 1'b0;
      data_o_q  <= '0;
      data_oe_q <= 1'b0;
      err_q     <= 1'b0;
      txn_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      gnt_q     <= gnt_d;
      data_o_q  <= data_o_d;
      data_oe_q <= data_oe_d;
      err_q     <= err_d;
      txn_cnt_q <= txn_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign data_o  = data_o_q;
  assign data_oe = data_oe_q;
  assign err     = err_q;
  assign txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_a_bus_responder.sv
// Bench for a_bus_responder: three instances (GNT_DELAY 1,2,3) share one stimulus
// stream and are checked every cycle against a timestamp-based transaction model.
module tb_a_bus_responder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req;
  logic [7:0] addr, data_i;
  logic [6:0] dbg_idx;

  logic        gnt_w [3];
  logic        oe_w  [3];
  logic        err_w [3];
  logic [7:0]  do_w  [3];
  logic [7:0]  dbg_w [3];
  logic [15:0] txn_w [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    a_bus_responder #(
      .GNT_DELAY (k + 1),
      .NUM_REGS  (16),
      .DATA_W    (8),
      .ADDR_W    (8)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .addr     (addr),
      .gnt      (gnt_w[k]),
      .data_i   (data_i),
      .data_o   (do_w[k]),
      .data_oe  (oe_w[k]),
      .err      (err_w[k]),
      .txn_cnt  (txn_w[k]),
      .dbg_idx  (dbg_idx),
      .dbg_data (dbg_w[k])
    );
  end

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input int k, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s d=%0d got=%h exp=%h at %0t", nm, k + 1, got, exp, $time);
    end
  endtask

  // Model: a request accepted at cycle c is granted in cycle c+delay; the
  // write lands and the count bumps when that grant cycle ends.
  bit         m_pend [3];
  int         m_due  [3];
  logic [7:0] m_a    [3];
  logic [7:0] m_mem  [3][16];
  int         m_txn  [3];
  bit         m_gnt  [3];
  int         cyc = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_pend[k] = 1'b0;
        m_gnt[k]  = 1'b0;
        m_txn[k]  = 0;
        m_a[k]    = 8'h00;
        for (int r = 0; r < 16; r++) m_mem[k][r] = 8'h00;
      end else begin
        if (m_gnt[k]) begin
          if (m_a[k][7] && m_a[k][6:0] < 7'd16) m_mem[k][m_a[k][3:0]] = data_i;
          if (m_txn[k] < 65535) m_txn[k]++;
          m_pend[k] = 1'b0;
        end else if (!m_pend[k] && req) begin
          m_pend[k] = 1'b1;
          m_due[k]  = cyc + k + 1;
          m_a[k]    = addr;
        end
        m_gnt[k] = m_pend[k] && (m_due[k] == cyc + 1);
      end
    end
    cyc++;
  end

  bit open   [3] = '{default: 1'b0};
  int start  [3];
  int ncyc = 0;

  always @(negedge clk) begin
    ncyc++;
    if (check_en) begin
      for (int k = 0; k < 3; k++) begin
        logic       inr;
        logic       e_oe, e_err;
        logic [7:0] e_do, e_dbg;
        inr   = m_a[k][6:0] < 7'd16;
        e_oe  = m_gnt[k] && !m_a[k][7];
        e_err = m_gnt[k] && !inr;
        e_do  = e_oe ? (inr ? m_mem[k][m_a[k][3:0]] : 8'hFF) : 8'h00;
        e_dbg = (dbg_idx < 7'd16) ? m_mem[k][dbg_idx[3:0]] : 8'h00;
        chk("gnt",      k, 16'(gnt_w[k]), 16'(m_gnt[k]));
        chk("data_oe",  k, 16'(oe_w[k]),  16'(e_oe));
        chk("err",      k, 16'(err_w[k]), 16'(e_err));
        chk("data_o",   k, 16'(do_w[k]),  16'(e_do));
        chk("dbg_data", k, 16'(dbg_w[k]), 16'(e_dbg));
        chk("txn_cnt",  k, txn_w[k],      16'(m_txn[k]));

        // Bus property req ##[1:3] gnt, observed from the initiator side.
        if (rst) begin
          open[k] = 1'b0;
        end else if (gnt_w[k] === 1'b1) begin
          if (open[k]) begin
            checks++;
            if (ncyc - start[k] < 1 || ncyc - start[k] > 3) begin
              failures++;
              $display("FAIL req_gnt_window d=%0d got=%0d exp=1..3", k + 1, ncyc - start[k]);
            end
          end
          open[k] = 1'b0;
        end else if (open[k] && ncyc - start[k] > 3) begin
          checks++;
          failures++;
          $display("FAIL req_gnt_timeout d=%0d got=%0d exp=1..3", k + 1, ncyc - start[k]);
          open[k] = 1'b0;
        end else if (!open[k] && req) begin
          open[k]  = 1'b1;
          start[k] = ncyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  pat;
  logic [15:0] txn0;

  initial begin
    rst = 1'b1; req = 1'b0; addr = 8'h00; data_i = 8'h00; dbg_idx = 7'd0;
    tick();
    check_en = 1'b1;
    tick();
    chk("rst_gnt", 1, 16'(gnt_w[1]), 16'h0);
    chk("rst_txn", 1, txn_w[1], 16'h0);
    chk("rst_do",  1, 16'(do_w[1]), 16'h0);
    rst = 1'b0;
    tick();

    // Read idx 3 after reset; grant position per delay.
    req = 1'b1; addr = 8'h03;
    tick();
    chk("A_gnt_c1", 0, 16'(gnt_w[0]), 16'h1);
    chk("A_gnt_c1", 1, 16'(gnt_w[1]), 16'h0);
    tick();
    chk("A_gnt_c2", 1, 16'(gnt_w[1]), 16'h1);
    chk("A_oe_c2",  1, 16'(oe_w[1]),  16'h1);
    chk("A_do_c2",  1, 16'(do_w[1]),  16'h00);
    chk("A_gnt_c2", 2, 16'(gnt_w[2]), 16'h0);
    tick();
    chk("A_gnt_c3", 1, 16'(gnt_w[1]), 16'h0);
    chk("A_gnt_c3", 2, 16'(gnt_w[2]), 16'h1);
    chk("A_txn",    1, txn_w[1],      16'h1);
    req = 1'b0;
    tick(); tick();

    // Write 0xA5 to idx 5, visible on the debug port the cycle after grant.
    req = 1'b1; addr = 8'h85; data_i = 8'hA5; dbg_idx = 7'd5;
    tick(); tick();
    chk("B_gnt",     1, 16'(gnt_w[1]), 16'h1);
    chk("B_oe",      1, 16'(oe_w[1]),  16'h0);
    chk("B_dbg_pre", 1, 16'(dbg_w[1]), 16'h00);
    tick();
    chk("B_dbg",     1, 16'(dbg_w[1]), 16'hA5);
    req = 1'b0;
    tick(); tick();

    req = 1'b1; addr = 8'h05;
    tick(); tick();
    chk("C_do", 1, 16'(do_w[1]), 16'hA5);
    chk("C_oe", 1, 16'(oe_w[1]), 16'h1);
    tick(); req = 1'b0;
    tick(); tick();

    // Out-of-range read and write.
    req = 1'b1; addr = 8'h20;
    tick(); tick();
    chk("D_gnt", 1, 16'(gnt_w[1]), 16'h1);
    chk("D_err", 1, 16'(err_w[1]), 16'h1);
    chk("D_do",  1, 16'(do_w[1]),  16'hFF);
    chk("D_oe",  1, 16'(oe_w[1]),  16'h1);
    tick();
    chk("D_err_after", 1, 16'(err_w[1]), 16'h0);
    req = 1'b0;
    tick(); tick();

    req = 1'b1; addr = 8'hA0; data_i = 8'h33;
    tick(); tick();
    chk("E_gnt", 1, 16'(gnt_w[1]), 16'h1);
    chk("E_err", 1, 16'(err_w[1]), 16'h1);
    chk("E_oe",  1, 16'(oe_w[1]),  16'h0);
    tick(); req = 1'b0;
    tick(); tick();
    dbg_idx = 7'd0;
    #1;
    chk("E_dbg0", 1, 16'(dbg_w[1]), 16'h00);
    for (int i = 0; i < 20; i++) begin
      dbg_idx = 7'(i);
      tick();
    end

    // Back-to-back with req held: delay-1 instance grants every other cycle.
    txn0 = txn_w[0];
    pat  = '0;
    req = 1'b1; addr = 8'h02;
    for (int j = 0; j < 6; j++) begin
      tick();
      pat[j] = gnt_w[0];
    end
    req = 1'b0;
    chk("F_gnt_pattern", 0, 16'(pat), 16'h0015);
    tick();
    chk("F_txn_delta", 0, txn_w[0] - txn0, 16'h3);
    tick(); tick(); tick();

    // Reset while waiting on a write: abandoned with no grant and no write.
    dbg_idx = 7'd1;
    req = 1'b1; addr = 8'h81; data_i = 8'h77;
    tick();
    rst = 1'b1; req = 1'b0;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("G_no_gnt", 1, 16'(gnt_w[1]), 16'h0);
      chk("G_no_gnt", 2, 16'(gnt_w[2]), 16'h0);
    end
    chk("G_reg1", 1, 16'(dbg_w[1]), 16'h00);
    chk("G_reg1", 2, 16'(dbg_w[2]), 16'h00);
    chk("G_txn",  1, txn_w[1],      16'h0);
    req = 1'b1; addr = 8'h01;
    tick(); tick();
    chk("G_regrant", 1, 16'(gnt_w[1]), 16'h1);
    chk("G_oe",      1, 16'(oe_w[1]),  16'h1);
    chk("G_do",      1, 16'(do_w[1]),  16'h00);
    tick(); req = 1'b0;
    tick(); tick();
    chk("G_txn_after", 1, txn_w[1], 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/a_bus_responder.md
Name: a_bus_responder

Overview:
- Synthesizable device-side (DUT-modport) end of the A_Bus req/gnt/addr/data protocol.
- Accepts requests from the testbench/initiator side and returns a single-cycle gnt 1..3 cycles after req, per the bus property req ##[1:3] gnt.
- Serves reads and writes against a small internal register file.
- The bidirectional data wire is split into data_i / data_o / data_oe; the tristate is resolved at the interface wrapper.

Parameters:
- GNT_DELAY, 2, cycles from accepted req to gnt; legal 1..3; elaboration error otherwise.
- NUM_REGS, 16, register file depth; legal 1..128.
- DATA_W, 8, data bus width.
- ADDR_W, 8, address bus width; bit ADDR_W-1 is the write flag.

Ports:
- clk  input  1  bus clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  request from initiator; held with addr stable until gnt is seen.
- addr  input  ADDR_W  bit[ADDR_W-1]=1 write, 0 read; bits[ADDR_W-2:0] = register index.
- gnt  output  1  single-cycle grant pulse.
- data_i  input  DATA_W  bus data sampled on write grant.
- data_o  output  DATA_W  read data.
- data_oe  output  1  drive enable for data_o.
- err  output  1  one-cycle pulse, coincident with gnt, when index >= NUM_REGS.
- txn_cnt  output  16  completed-transaction count, saturating at 16'hFFFF.
- dbg_idx  input  7  backdoor register index.
- dbg_data  output  DATA_W  combinational regfile[dbg_idx]; 0 when out of range.

Behaviour:
- Reset: gnt, data_oe, err = 0; data_o = 0; txn_cnt = 0; all registers = 0; state = IDLE. Reset wins over everything.
- Reset mid-transaction abandons it: no gnt is issued and no write is performed.
- States: IDLE, WAIT, GRANT. All outputs are registered.
- IDLE, req=1 at cycle t:
  - Latch addr into a_q; load cnt = GNT_DELAY-1.
  - Go to GRANT if GNT_DELAY==1, else WAIT.
- WAIT: decrement cnt; when cnt==1, go to GRANT. req and addr changes are ignored (a_q is used).
- GRANT: lasts exactly one cycle, at t+GNT_DELAY; gnt=1.
  - Read, index in range: data_o = reg[idx], data_oe = 1.
  - Read, out of range: data_o = all-ones, data_oe = 1, err = 1.
  - Write, in range: reg[idx] <= data_i at the end of the GRANT cycle; data_oe = 0.
  - Write, out of range: write dropped, err = 1.
  - txn_cnt increments (saturating).
  - Next state: IDLE.
- data_oe is high only during a read GRANT; data_o returns to 0 afterwards.
- req sampled in GRANT is ignored.
- req still high in the first IDLE cycle after GRANT is a new request using addr at that cycle. Back-to-back period = GNT_DELAY+1 cycles.
- req dropped before gnt (protocol violation): the transaction still completes with gnt; no assertion is required in RTL.
- dbg_data reflects a write from the cycle after GRANT.

Decomposition:
- a_bus_pkg holds:
  - resp_state_e enum (IDLE, WAIT, GRANT).
  - ADDR_W and DATA_W defaults.
  - WR_BIT = ADDR_W-1.
  - ERR_DATA = all-ones.
  - Function idx_of(addr).
- One sub-module, a_bus_regfile: NUM_REGS x DATA_W, synchronous write with sync clear on rst, two combinational read ports (bus and debug), out-of-range read returns 0.

Test Plan:
- GNT_DELAY=2, read idx 3 after reset: req=1, addr=8'h03 at cycle 0 -> gnt=1, data_oe=1, data_o=8'h00 at cycle 2 only; txn_cnt=1.
- Write then read: addr=8'h85, data_i=8'hA5, gnt seen -> dbg_data(idx5)=8'hA5 next cycle; then read addr=8'h05 -> data_o=8'hA5 on gnt.
- Sweep GNT_DELAY 1, 2, 3: gnt exactly 1/2/3 cycles after req accepted; bench property req ##[1:3] gnt always passes.
- Out of range, NUM_REGS=16:
  - Read 8'h20 -> gnt=1, err=1, data_o=8'hFF.
  - Write 8'hA0 -> err=1, no regfile change.
- Back-to-back with req held high for 3 transactions, GNT_DELAY=1 -> gnt at cycles 1, 3, 5; txn_cnt=3.
- rst=1 in WAIT after write req 8'h81 -> no gnt, reg[1]=0, state IDLE; next req grants normally.
